// File: rtl/rr_burst_scheduler_pkg.sv
// Shared types and helpers for the round-robin burst scheduler: FSM state
// encoding, default sizing and the rotating-priority winner pick.
package rr_burst_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned RR_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // First asserted request scanning ptr, ptr+1, ... modulo n (n <= RR_MAX).
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int unsigned       n);
    logic [2:0]  win;
    logic        found;
    int unsigned cand;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      cand = (32'(ptr) + k) % n;
      if (!found && (k < n) && req[cand[2:0]]) begin
        win   = cand[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_burst_scheduler_if.sv
// Client-facing bundle of the burst scheduler: request/length lines in,
// grant, beat and completion status out.
interface rr_burst_scheduler_if #(
  parameter  int N_REQ = rr_burst_pkg::N_REQ_DEF,
  parameter  int CNT_W = rr_burst_pkg::CNT_W_DEF,
  localparam int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   beat;
  logic [CNT_W-1:0]       count;
  logic                   last;
  logic [N_REQ-1:0]       done;
  logic                   aborted;
  logic                   busy;

  modport master (
    output req, len,
    input  grant, grant_idx, beat, count, last, done, aborted, busy
  );

  modport slave (
    input  req, len,
    output grant, grant_idx, beat, count, last, done, aborted, busy
  );
endinterface

// File: rtl/rr_burst_scheduler_counter.sv
// Shared CNT_W-bit beat counter: synchronous clear has priority over enable;
// tc_o flags the all-ones value.
module burst_counter #(
  parameter int CNT_W = rr_burst_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i)  count_q <= count_q + 1'b1;
  end

  assign count_o = count_q;
  assign tc_o    = &count_q;
endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin owner of one shared burst counter: grants a requester for
// len+1 beats, then reports completion (or abort on req drop) for one cycle.
module rr_burst_scheduler
  import rr_burst_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  rr_burst_scheduler_if.slave bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             aborted_q, aborted_d;
  logic [IDX_W-1:0] win;
  logic [CNT_W-1:0] count;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             own_req, at_last;

  assign win     = IDX_W'(rr_pick(8'(bus.req), 3'(ptr_q), N_REQ));
  assign own_req = bus.req[idx_q];
  assign at_last = (count == len_q);

  burst_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (count),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      len_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    aborted_d = aborted_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          idx_d     = win;
          len_d     = bus.len[int'(win)*CNT_W +: CNT_W];
          aborted_d = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // A dropped request wins over reaching the last beat; the counter freezes.
        if (!own_req) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (at_last) begin
          aborted_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_en = !cnt_tc;
        end
      end
      DONE: begin
        ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = (state_q == RUN)  ? (N_REQ'(1) << idx_q) : '0;
  assign bus.done      = (state_q == DONE) ? (N_REQ'(1) << idx_q) : '0;
  assign bus.grant_idx = idx_q;
  assign bus.beat      = (state_q == RUN);
  assign bus.count     = count;
  assign bus.last      = (state_q == RUN) && at_last;
  assign bus.aborted   = (state_q == DONE) && aborted_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Self-checking bench for rr_burst_scheduler: table-driven bursts plus hand
// sequences for abort, mid-burst reset and back-to-back round robin.
module tb_rr_burst_scheduler;
  import rr_burst_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_burst_scheduler_if #(.N_REQ(N), .CNT_W(W)) bus ();
  rr_burst_scheduler #(.N_REQ(N), .CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [N-1:0] done_exp;
    logic         ab_exp;
    int           beats;
    logic [W-1:0] len_exp;
  } exp_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   win;
    logic [W-1:0]   wlen;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: per-beat count/last/grant checks, scoreboard pop on each done.
  initial begin
    int beat_n;
    beat_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        beat_n = 0;
      end else begin
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check("done_onehot0", 32'($onehot0(bus.done)), 32'd1);
        check("grant_done_excl", 32'((bus.grant != '0) && (bus.done != '0)), 32'd0);
        if (bus.beat) begin
          if (sb.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
          else begin
            check("grant", bus.grant, sb[0].done_exp);
            check("count", bus.count, beat_n);
            check("last", bus.last, 32'(beat_n == int'(sb[0].len_exp)));
            beat_n++;
          end
        end
        if (bus.done != '0) begin
          if (sb.size() == 0) check("done_unexpected", bus.done, 32'd0);
          else begin
            check("done", bus.done, sb[0].done_exp);
            check("aborted", bus.aborted, sb[0].ab_exp);
            check("beats", beat_n, sb[0].beats);
            $display("burst done=%b aborted=%0d beats=%0d", bus.done, bus.aborted, beat_n);
            void'(sb.pop_front());
            beat_n = 0;
          end
        end
      end
    end
  end

  initial begin
    int t_beat[5];
    int nb;
    int nd;
    bit hit;

    vt[0] = '{4'b0001, 16'h0003, 4'b0001, 4'd3};
    vt[1] = '{4'b0100, 16'h0F00, 4'b0100, 4'd15};
    vt[2] = '{4'b1001, 16'h1002, 4'b1000, 4'd1};
    vt[3] = '{4'b1001, 16'h5000, 4'b0001, 4'd0};
    vt[4] = '{4'b1001, 16'h2007, 4'b1000, 4'd2};
    vt[5] = '{4'b0110, 16'h0350, 4'b0010, 4'd5};
    vt[6] = '{4'b0011, 16'h0042, 4'b0001, 4'd2};

    rst = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", bus.grant, 32'd0);
    check("rst_grant_idx", bus.grant_idx, 32'd0);
    check("rst_beat", bus.beat, 32'd0);
    check("rst_count", bus.count, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_done", bus.done, 32'd0);
    rst = 1'b0;

    // Table-driven bursts; len is scrambled after grant to prove it was sampled.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      bus.req = vt[v].req;
      bus.len = vt[v].len;
      sb.push_back('{vt[v].win, 1'b0, int'(vt[v].wlen) + 1, vt[v].wlen});
      @(negedge clk);
      check("grant_latency", bus.grant, vt[v].win);
      check("busy_run", bus.busy, 32'd1);
      $display("vec %0d req=%b grant=%b idx=%0d", v, vt[v].req, bus.grant, bus.grant_idx);
      bus.len = ~vt[v].len;
      wait_done();
      bus.req = '0;
    end

    // Abort: requester 1 drops req during the count==2 beat.
    @(negedge clk);
    bus.req = 4'b0010;
    bus.len = 16'h0070;
    sb.push_back('{4'b0010, 1'b1, 3, 4'd7});
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      if (bus.beat && bus.count == 4'd2) hit = 1'b1;
    end
    check("abort_reach_count2", hit, 32'd1);
    bus.req = '0;
    wait_done();
    check("abort_count_done", bus.count, 32'd2);
    @(negedge clk);
    check("abort_count_idle", bus.count, 32'd2);
    check("abort_busy_idle", bus.busy, 32'd0);

    // Reset mid-burst at count 5: outputs clear at once, no done follows.
    bus.req = 4'b0100;
    bus.len = 16'h0900;
    sb.push_back('{4'b0100, 1'b0, 10, 4'd9});
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      if (bus.beat && bus.count == 4'd5) hit = 1'b1;
    end
    check("rst_reach_count5", hit, 32'd1);
    #1 rst = 1'b1;
    bus.req = '0;
    #1;
    check("midrst_grant", bus.grant, 32'd0);
    check("midrst_beat", bus.beat, 32'd0);
    check("midrst_count", bus.count, 32'd0);
    check("midrst_last", bus.last, 32'd0);
    check("midrst_busy", bus.busy, 32'd0);
    check("midrst_done", bus.done, 32'd0);
    check("midrst_grant_idx", bus.grant_idx, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All four held with len=0: rotation from ptr 0, 1-beat bursts, 3-cycle spacing.
    @(negedge clk);
    bus.len = '0;
    bus.req = 4'b1111;
    sb.push_back('{4'b0001, 1'b0, 1, 4'd0});
    sb.push_back('{4'b0010, 1'b0, 1, 4'd0});
    sb.push_back('{4'b0100, 1'b0, 1, 4'd0});
    sb.push_back('{4'b1000, 1'b0, 1, 4'd0});
    sb.push_back('{4'b0001, 1'b0, 1, 4'd0});
    nb = 0;
    nd = 0;
    for (int k = 0; k < 60 && nd < 5; k++) begin
      @(negedge clk);
      if (bus.beat && nb < 5) begin
        t_beat[nb] = cyc;
        nb++;
      end
      if (bus.done != '0) begin
        nd++;
        if (nd == 5) bus.req = '0;
      end
    end
    check("rr_bursts", nd, 32'd5);
    check("rr_beats", nb, 32'd5);
    for (int i = 0; i < 4; i++)
      check("rr_gap", t_beat[i+1] - t_beat[i], 32'd3);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("final_busy", bus.busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_burst_scheduler.md
Name: rr_burst_scheduler

Overview:
- Round-robin scheduler that shares one CNT_W-bit burst counter between N_REQ requesters.
- Each winner gets exclusive use of the counter for a programmed burst of (len+1) beats.
- Sits between client request lines and the shared counting datapath; sequences clear/enable of the counter and reports completion per requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 4, burst counter width; max burst = 2^CNT_W beats
IDX_W, $clog2(N_REQ), requester index width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  N_REQ  per-requester request, level; held until done or abort
len  input  N_REQ*CNT_W  packed burst lengths; slice i = len[i*CNT_W +: CNT_W]; sampled only at grant
grant  output  N_REQ  one-hot, high during RUN for the owner
grant_idx  output  IDX_W  binary index of current/last owner
beat  output  1  high every RUN cycle (counter enable)
count  output  CNT_W  current beat number within burst, 0-based
last  output  1  high in the final beat of a burst
done  output  N_REQ  one-cycle one-hot pulse in DONE state
aborted  output  1  valid with done; 1 if burst ended by req drop
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1, async): state=IDLE, grant=0, grant_idx=0, beat=0, count=0, last=0, done=0, aborted=0, busy=0, rr pointer=0 (requester 0 highest priority). Reset mid-burst discards the burst; no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If |req=0, remain in IDLE.
  - Otherwise select winner = first asserted req scanning from ptr, ptr+1, ... mod N_REQ.
  - Latch winner index and its len slice into len_q; clear counter to 0; go to RUN.
  - Latency req→grant is 1 cycle.
- RUN:
  - grant[idx]=1, beat=1, busy=1, counter increments each cycle; count shows 0,1,...,len_q.
  - last=1 when count==len_q; next state DONE with aborted=0.
  - If req[idx]=0 in any RUN cycle (including the last): beat still=1 that cycle, next state DONE with aborted=1; counter frozen.
  - Requests from other requesters are ignored during RUN.
- DONE (exactly 1 cycle):
  - done[idx]=1, aborted per above, grant=0, beat=0, busy=1.
  - ptr <= (idx+1) mod N_REQ.
  - Next state IDLE.
- Burst occupancy: len_q+1 RUN cycles. Turnaround DONE→IDLE→RUN gives 2 non-RUN cycles between bursts.
- Width rules:
  - len=0 gives a 1-beat burst; last is high in the same cycle as beat.
  - len=2^CNT_W-1 gives a full burst; last coincides with counter terminal count (all ones).
  - Counter never wraps inside a burst.
- Requester still asserting req in DONE re-competes in IDLE at lowest priority.
- Requests are never lost: a req held through a burst is served within N_REQ-1 further bursts.
- count holds its last value outside RUN; it is cleared only on a new grant or rst.
- Invariants: grant is one-hot or zero; done is one-hot or zero; grant and done are never both nonzero.

Decomposition:
- Package rr_burst_pkg: state enum (IDLE, RUN, DONE) and default N_REQ/CNT_W constants.
- Sub-module burst_counter: CNT_W up-counter with clk, rst, clr, en, count, tc (terminal count). Instanced once.
- Round-robin pick is a function in the package.

Test Plan:
1. req=0001, len[0]=3 → grant=0001 from cycle 1 for 4 cycles; count 0,1,2,3; last at count=3; done=0001 next cycle; aborted=0.
2. req=1111 held, all len=0 → grants in order 0001,0010,0100,1000,0001; each burst 1 beat with last=1; 2-cycle gaps.
3. req[2] only, len[2]=15 → 16 beats, count reaches 15, last=1 at count 15, no wrap; done=0100.
4. req=0010, len[1]=7, req[1] drops after count=2 → beat for counts 0..2; done=0010 with aborted=1; count holds 2.
5. rst asserted mid-burst at count=5 → all outputs 0 immediately; no done pulse; next grant goes to lowest requester index (ptr=0).
6. req=1001, ptr=1 after serving 0 → winner=3, not 0; len sampled at grant, so a len change during RUN has no effect.
